// File: rtl/sevenseg_decoder_if.sv
// sevenseg_decoder_if: multiplexed seven-segment bus in, decoded digit table and pulses out.
interface sevenseg_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDXW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
);
  logic                    sample_en;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [6:0]              segments;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic [IDXW-1:0]         update_idx;
  logic                    err_invalid;
  logic                    err_sel;
  modport master (
    output sample_en, digit_sel, segments,
    input  digits, digit_valid, update, update_idx, err_invalid, err_sel
  );
  modport slave (
    input  sample_en, digit_sel, segments,
    output digits, digit_valid, update, update_idx, err_invalid, err_sel
  );
endinterface

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: per-digit stability filter and 7-segment to BCD decode of a multiplexed bus.
module sevenseg_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int IDXW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input logic clk,
  input logic reset_n,
  sevenseg_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CNT);
  logic [6:0]              last_pat_q [NUM_DIGITS];
  logic [6:0]              last_pat_d [NUM_DIGITS];
  logic [CW-1:0]           cnt_q [NUM_DIGITS];
  logic [CW-1:0]           cnt_d [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [IDXW-1:0]         idx_q, idx;
  logic                    update_q, err_inv_q, err_sel_q;
  logic                    multi, one_hot, same, commit, legal;
  logic [3:0]              dec;
  always_comb begin
    legal = 1'b1;
    case (bus.segments)
      7'b1111110: dec = 4'd0;
      7'b0110000: dec = 4'd1;
      7'b1101101: dec = 4'd2;
      7'b1111001: dec = 4'd3;
      7'b0110011: dec = 4'd4;
      7'b1011011: dec = 4'd5;
      7'b1011111: dec = 4'd6;
      7'b1110000: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1110011: dec = 4'd9;
      default: begin dec = 4'hF; legal = 1'b0; end
    endcase
  end
  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) if (bus.digit_sel[k]) idx = IDXW'(k);
    multi = bus.sample_en && ((bus.digit_sel & (bus.digit_sel - NUM_DIGITS'(1))) != '0);
    one_hot = bus.sample_en && bus.digit_sel != '0 && !multi;
    last_pat_d = last_pat_q;
    cnt_d = cnt_q;
    digits_d = digits_q;
    valid_d = valid_q;
    same = bus.segments == last_pat_q[idx];
    commit = 1'b0;
    if (one_hot) begin
      last_pat_d[idx] = bus.segments;
      cnt_d[idx] = !same ? CW'(1) : cnt_q[idx] == FULL ? FULL : cnt_q[idx] + CW'(1);
      // a saturated run never commits again until the pattern changes
      commit = cnt_d[idx] == FULL && !(same && cnt_q[idx] == FULL);
    end
    if (commit) begin
      digits_d[4*idx +: 4] = dec;
      valid_d[idx] = legal;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        last_pat_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      digits_q <= '1;
      valid_q <= '0;
      update_q <= 1'b0;
      idx_q <= '0;
      err_inv_q <= 1'b0;
      err_sel_q <= 1'b0;
    end else begin
      last_pat_q <= last_pat_d;
      cnt_q <= cnt_d;
      digits_q <= digits_d;
      valid_q <= valid_d;
      update_q <= commit;
      if (commit) idx_q <= idx;
      err_inv_q <= commit && !legal && bus.segments != 7'b0;
      err_sel_q <= multi;
    end
  end
  assign bus.digits = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.update = update_q;
  assign bus.update_idx = idx_q;
  assign bus.err_invalid = err_inv_q;
  assign bus.err_sel = err_sel_q;
endmodule

// File: tb/tb_sevenseg_decoder.sv
// tb_sevenseg_decoder: directed vectors against hand-computed digit table and pulse values.
module tb_sevenseg_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  sevenseg_decoder_if #(.NUM_DIGITS(4)) bus ();
  sevenseg_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic smp(input logic [3:0] sel, input logic [6:0] seg);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.digit_sel = sel;
    bus.segments = seg;
    @(posedge clk);
    #1 bus.sample_en = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask
  task automatic chk_idle_out(input string tag);
    chk({tag, "_digits"}, bus.digits, 32'hFFFF);
    chk({tag, "_valid"}, bus.digit_valid, 4'b0000);
    chk({tag, "_pulses"}, {bus.update, bus.err_invalid, bus.err_sel}, 3'b000);
    chk({tag, "_idx"}, bus.update_idx, 2'd0);
  endtask
  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
  initial begin
    bus.sample_en = 1'b0;
    bus.digit_sel = '0;
    bus.segments = '0;
    repeat (4) begin
      @(negedge clk);
      bus.sample_en = 1'($urandom);
      bus.digit_sel = 4'($urandom);
      bus.segments = 7'($urandom);
    end
    #1 chk_idle_out("reset");
    @(negedge clk);
    bus.sample_en = 1'b0;
    reset_n = 1'b1;
    idle(3);
    chk_idle_out("post_reset");
    for (int k = 0; k < 2; k++) begin
      smp(4'b0010, pat[2]);
      chk("stable_early_upd", bus.update, 1'b0);
    end
    smp(4'b0010, pat[2]);
    chk("stable_upd", bus.update, 1'b1);
    chk("stable_idx", bus.update_idx, 2'd1);
    chk("stable_digits", bus.digits, 32'hFF2F);
    chk("stable_valid", bus.digit_valid, 4'b0010);
    smp(4'b0010, pat[2]);
    chk("stable_4th_upd", bus.update, 1'b0);
    chk("stable_4th_digits", bus.digits, 32'hFF2F);
    smp(4'b0001, pat[3]);
    smp(4'b0001, pat[3]);
    chk("glitch_s2_upd", bus.update, 1'b0);
    smp(4'b0001, pat[1]);
    chk("glitch_s3_upd", bus.update, 1'b0);
    smp(4'b0001, pat[3]);
    smp(4'b0001, pat[3]);
    chk("glitch_s5_upd", bus.update, 1'b0);
    chk("glitch_s5_digits", bus.digits, 32'hFF2F);
    smp(4'b0001, pat[3]);
    chk("glitch_upd", bus.update, 1'b1);
    chk("glitch_idx", bus.update_idx, 2'd0);
    chk("glitch_digits", bus.digits, 32'hFF23);
    chk("glitch_valid", bus.digit_valid, 4'b0011);
    do_reset();
    idle(1);
    chk_idle_out("reset2");
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) begin
        smp(4'b0001 << d, pat[d+1]);
        chk($sformatf("scan_r%0d_d%0d_upd", r, d), bus.update, r == 2);
        if (r == 2) chk($sformatf("scan_d%0d_idx", d), bus.update_idx, d);
      end
    chk("scan_digits", bus.digits, 32'h4321);
    chk("scan_valid", bus.digit_valid, 4'b1111);
    idle(1);
    chk("scan_upd_clear", bus.update, 1'b0);
    for (int k = 0; k < 3; k++) smp(4'b0100, 7'b0000001);
    chk("illegal_pulses", {bus.update, bus.err_invalid}, 2'b11);
    chk("illegal_idx", bus.update_idx, 2'd2);
    chk("illegal_digits", bus.digits, 32'h4F21);
    chk("illegal_valid", bus.digit_valid, 4'b1011);
    idle(1);
    chk("illegal_clear", {bus.update, bus.err_invalid}, 2'b00);
    for (int k = 0; k < 3; k++) smp(4'b0100, 7'b0000000);
    chk("blank_pulses", {bus.update, bus.err_invalid}, 2'b10);
    chk("blank_digits", bus.digits, 32'h4F21);
    chk("blank_valid", bus.digit_valid, 4'b1011);
    @(negedge clk);
    bus.digit_sel = 4'b0001;
    bus.segments = pat[8];
    idle(4);
    chk("sample_en_low", {bus.update, bus.err_sel, bus.digits}, {2'b00, 16'h4F21});
    smp(4'b0110, pat[9]);
    chk("err_sel_pulse", {bus.err_sel, bus.update}, 2'b10);
    idle(1);
    chk("err_sel_clear", bus.err_sel, 1'b0);
    smp(4'b0000, pat[9]);
    chk("blank_sel", {bus.err_sel, bus.update}, 2'b00);
    smp(4'b1000, pat[9]);
    smp(4'b1000, pat[9]);
    chk("pre_reset_upd", bus.update, 1'b0);
    do_reset();
    idle(1);
    chk_idle_out("reset3");
    smp(4'b1000, pat[9]);
    smp(4'b1000, pat[9]);
    chk("post_reset_s2_upd", bus.update, 1'b0);
    smp(4'b1000, pat[9]);
    chk("post_reset_upd", bus.update, 1'b1);
    chk("post_reset_idx", bus.update_idx, 2'd3);
    chk("post_reset_digits", bus.digits, 32'h9FFF);
    chk("post_reset_valid", bus.digit_valid, 4'b1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sevenseg_decoder.md
Name: sevenseg_decoder

Overview:
- Receive-side counterpart of the team's 4-bit-to-7-segment encoder.
- Samples a time-multiplexed seven-segment bus (one-hot digit select plus a shared segment vector).
- Filters each digit's pattern for stability, then decodes it back to a 4-bit BCD value.
- Holds a registered per-digit value/valid table for self-check benches and display loopback tests.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (>=1).
- STABLE_CNT, 3, consecutive identical samples required before a pattern is committed (>=1).
- IDXW, $clog2(NUM_DIGITS) (minimum 1), derived width of the digit index.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies a sample on this edge.
- digit_sel  input  NUM_DIGITS  one-hot active digit; bit i selects digit i.
- segments  input  7  active-high segments, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digits  output  4*NUM_DIGITS  decoded values; digit i occupies [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i = 1 when digit i holds a committed legal decimal pattern.
- update  output  1  one-cycle pulse: a digit was committed.
- update_idx  output  IDXW  index of the committed digit; valid while update=1.
- err_invalid  output  1  one-cycle pulse: an illegal non-blank pattern was committed.
- err_sel  output  1  one-cycle pulse: a sample was taken with multi-hot digit_sel.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - digits = all 4'hF; digit_valid = 0; update = 0; update_idx = 0; err_invalid = 0; err_sel = 0.
  - Internal per-digit last_pat = 7'b0000000 and cnt = 0.
  - Reset asserted mid-run discards all partial stability counts.
- Legal patterns (the only accepted codes):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1110011
- Sample taken only on a rising edge with sample_en=1. With sample_en=0 there is no state change and all pulses are 0.
- digit_sel all zero (blanking interval): sample ignored, no pulse.
- digit_sel multi-hot: sample ignored, no counter change, err_sel=1 for the following cycle.
- digit_sel one-hot at index i:
  - If segments == last_pat[i]: cnt[i] increments, saturating at STABLE_CNT.
  - Otherwise: last_pat[i] <= segments and cnt[i] <= 1.
- Commit occurs on the sample edge where cnt[i] first reaches STABLE_CNT, i.e. the STABLE_CNT-th consecutive identical sample of digit i.
  - Samples of other digits between those samples do not break the run; only digit i's own samples count.
  - After the commit edge, update=1 and update_idx=i for exactly one cycle.
  - Exactly one commit per stable run. Further identical samples produce no update.
  - With STABLE_CNT=1, every change of pattern commits immediately.
- Commit result by pattern:
  - Legal pattern: digits[i] <= decoded value, digit_valid[i] <= 1.
  - 7'b0000000 (blank): digits[i] <= 4'hF, digit_valid[i] <= 0, no error pulse.
  - Any other pattern: digits[i] <= 4'hF, digit_valid[i] <= 0, err_invalid=1 in the same cycle as update.
- A pattern change before reaching STABLE_CNT leaves the previous committed value and valid flag untouched.
- Latency: outputs reflect a commit in the cycle immediately after the committing edge. All outputs are registered.
- Only one digit can commit per cycle, because one-hot select guarantees it. Pulses never overlap for different indices.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> digits=16'hFFFF, digit_valid=4'b0000, all pulses 0. Release and stay idle -> outputs unchanged.
- Stable commit: digit_sel=4'b0010, segments=1101101 for 3 sample cycles -> after the 3rd edge update=1 for 1 cycle, update_idx=1, digits[7:4]=4'h2, digit_valid=4'b0010. A 4th identical sample -> no update.
- Glitch filter: digit 0 sequence 1111001, 1111001, 0110000, 1111001, 1111001, 1111001 -> exactly one update, after the 6th sample, with digits[3:0]=4'h3. No update at samples 2 or 3.
- Interleaved scan: round-robin digits 0..3 carrying 1,2,3,4, each shown 3 times -> 4 updates with idx 0,1,2,3. digits=16'h4321, digit_valid=4'b1111.
- Illegal/blank: digit 2 stable on 0000001 -> err_invalid and update together, digits[11:8]=4'hF, digit_valid[2]=0. Then stable on 0000000 -> update with no err_invalid.
- Select errors and reset mid-run: digit_sel=4'b0110 with sample_en=1 -> err_sel pulse, no counter change. Then 2 samples of 9 on digit 3, pulse reset_n low, then 2 more samples -> no commit. The 3rd sample after reset -> digits[15:12]=4'h9.
